// File: rtl/ascii_int32_converter_pkg.sv
// Shared types and constants for the ascii_num_sep number path.
package ascii_num_pkg;

    localparam int unsigned CHAR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAG_W  = 34;
    localparam int unsigned PROD_W = 38;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_BAD_CHAR = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_EMPTY    = 2'd3
    } err_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } conv_state_t;

    // Running conversion state for the token being accumulated
    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic             neg;
        logic             seen_digit;
        logic             bad_char;
        logic             ovf;
    } acc_t;

    localparam logic [CHAR_W-1:0] ASCII_MINUS   = 8'h2D;
    localparam logic [CHAR_W-1:0] ASCII_ZERO    = 8'h30;
    localparam logic [CHAR_W-1:0] ASCII_NINE    = 8'h39;
    localparam logic [CHAR_W-1:0] ASCII_SPACE   = 8'h20;
    localparam logic [DATA_W-1:0] INT32_MAX     = 32'h7FFF_FFFF;
    localparam logic [MAG_W-1:0]  INT32_MIN_MAG = 34'h0_8000_0000;

    function automatic logic is_digit(input logic [CHAR_W-1:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/ascii_int32_converter_if.sv
// Character stream in, conversion result out.
interface ascii_int32_converter_if;
    import ascii_num_pkg::*;

    logic              num_start;
    logic [CHAR_W-1:0] num_char;
    logic              num_valid;
    logic              num_end;
    logic              result_valid;
    logic [DATA_W-1:0] result_value;
    err_t              result_err;

    modport master (
        output num_start, num_char, num_valid, num_end,
        input  result_valid, result_value, result_err
    );

    modport slave (
        input  num_start, num_char, num_valid, num_end,
        output result_valid, result_value, result_err
    );
endinterface

// File: rtl/ascii_int32_converter_dec_digit_mac.sv
// Combinational mag*10+digit with clamp to the signed INT32 limit.
module dec_digit_mac
    import ascii_num_pkg::*;
(
    input  logic [MAG_W-1:0] mag_in,
    input  logic [3:0]       digit,
    input  logic             neg,
    output logic [MAG_W-1:0] mag_out_c,
    output logic             ovf_c
);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] limit;

    // Wide product so any 34-bit input is compared without wrap
    always_comb begin
        prod      = PROD_W'(mag_in) * PROD_W'(10) + PROD_W'(digit);
        limit     = neg ? PROD_W'(INT32_MIN_MAG) : PROD_W'(INT32_MAX);
        ovf_c     = prod > limit;
        mag_out_c = ovf_c ? MAG_W'(limit) : MAG_W'(prod);
    end
endmodule

// File: rtl/ascii_int32_converter.sv
// Converts one decimal character token into a signed 32-bit result.
module ascii_int32_converter
    import ascii_num_pkg::*;
#(
    parameter int unsigned CNT_W    = 11,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    ascii_int32_converter_if.slave  bus,
    output logic [CNT_W-1:0]        conv_count,
    output logic [CNT_W-1:0]        err_count
);
    conv_state_t       state_q, state_d;
    acc_t              acc_q, acc_d;
    acc_t              base_c, step_c;
    logic              result_valid_q, result_valid_d;
    logic [DATA_W-1:0] value_q, value_d;
    err_t              err_q, err_d;
    logic [CNT_W-1:0]  conv_q, conv_d;
    logic [CNT_W-1:0]  errc_q, errc_d;
    logic              tok_start_c;
    logic              done_c;
    logic [MAG_W-1:0]  mac_mag_c;
    logic              mac_ovf_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign tok_start_c = bus.num_start & bus.num_valid;

    dec_digit_mac u_mac (
        .mag_in    (base_c.mag),
        .digit     (bus.num_char[3:0]),
        .neg       (base_c.neg),
        .mag_out_c (mac_mag_c),
        .ovf_c     (mac_ovf_c)
    );

    // Apply the current character to the running token (fresh on num_start)
    always_comb begin
        base_c = tok_start_c ? '0 : acc_q;
        step_c = base_c;
        if (bus.num_char == ASCII_MINUS) begin
            if (tok_start_c) step_c.neg      = 1'b1;
            else             step_c.bad_char = 1'b1;
        end else if (is_digit(bus.num_char)) begin
            step_c.mag        = mac_mag_c;
            step_c.ovf        = base_c.ovf | mac_ovf_c;
            step_c.seen_digit = 1'b1;
        end else begin
            step_c.bad_char = 1'b1;
        end
    end

    // Next state, result selection and counters
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        result_valid_d = 1'b0;
        value_d        = value_q;
        err_d          = err_q;
        conv_d         = conv_q;
        errc_d         = errc_q;
        done_c         = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                if (bus.num_valid) acc_d  = step_c;
                if (bus.num_end)   done_c = 1'b1;
            end
            ST_IDLE, ST_FINISH: begin
                state_d = ST_IDLE;
                if (tok_start_c) begin
                    acc_d   = step_c;
                    state_d = ST_ACCUM;
                    done_c  = bus.num_end;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done_c) begin
            state_d        = ST_FINISH;
            result_valid_d = 1'b1;
            if (acc_d.bad_char) begin
                err_d   = ERR_BAD_CHAR;
                value_d = '0;
            end else if (!acc_d.seen_digit) begin
                err_d   = ERR_EMPTY;
                value_d = '0;
            end else if (acc_d.ovf) begin
                err_d = ERR_OVERFLOW;
                if (!SATURATE)      value_d = '0;
                else if (acc_d.neg) value_d = DATA_W'(INT32_MIN_MAG);
                else                value_d = INT32_MAX;
            end else begin
                err_d   = ERR_OK;
                value_d = acc_d.neg ? DATA_W'(-acc_d.mag) : DATA_W'(acc_d.mag);
            end
            conv_d = sat_inc(conv_q);
            if (err_d != ERR_OK) errc_d = sat_inc(errc_q);
            acc_d = '0;
        end

        if (clear) begin
            state_d        = ST_IDLE;
            acc_d          = '0;
            result_valid_d = 1'b0;
            value_d        = '0;
            err_d          = ERR_OK;
            conv_d         = '0;
            errc_d         = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            acc_q          <= '0;
            result_valid_q <= 1'b0;
            value_q        <= '0;
            err_q          <= ERR_OK;
            conv_q         <= '0;
            errc_q         <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            result_valid_q <= result_valid_d;
            value_q        <= value_d;
            err_q          <= err_d;
            conv_q         <= conv_d;
            errc_q         <= errc_d;
        end
    end

    assign bus.result_valid = result_valid_q;
    assign bus.result_value = value_q;
    assign bus.result_err   = err_q;
    assign conv_count       = conv_q;
    assign err_count        = errc_q;
endmodule

// File: tb/tb_ascii_int32_converter.sv
// Scoreboard bench: saturating and non-saturating converters driven in parallel.
module tb_ascii_int32_converter;

    typedef byte bq_t[$];
    typedef struct {
        logic [31:0] value;
        int          err;
        longint      t;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clear;
    logic [10:0] conv_s, err_s, conv_z, err_z;

    ascii_int32_converter_if bus_s ();
    ascii_int32_converter_if bus_z ();

    ascii_int32_converter #(.CNT_W(11), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_s),
        .conv_count(conv_s), .err_count(err_s)
    );
    ascii_int32_converter #(.CNT_W(11), .SATURATE(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_z),
        .conv_count(conv_z), .err_count(err_z)
    );

    int checks = 0;
    int errors = 0;
    int pulses_s = 0;
    int pulses_z = 0;
    int exp_conv = 0;
    int exp_err = 0;
    exp_t exp_s_q[$];
    exp_t exp_z_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference: decimal value from significant digits, then range test
    task automatic model(input bq_t tok, input bit sat, output logic [31:0] value, output int err);
        bit neg = 0, bad = 0, seen = 0, ovf;
        int sig = 0;
        longint v = 0, limit;
        for (int i = 0; i < tok.size(); i++) begin
            byte c = tok[i];
            if (c == "-") begin
                if (i == 0) neg = 1; else bad = 1;
            end else if (c >= "0" && c <= "9") begin
                seen = 1;
                if (sig > 0 || c != "0") begin
                    sig++;
                    if (sig <= 10) v = v * 10 + longint'(c - "0");
                end
            end else begin
                bad = 1;
            end
        end
        limit = neg ? 64'd2147483648 : 64'd2147483647;
        ovf = (sig > 10) || (v > limit);
        if (bad)        begin err = 1; value = 0; end
        else if (!seen) begin err = 3; value = 0; end
        else if (ovf)   begin err = 2; value = !sat ? 32'h0 : (neg ? 32'h8000_0000 : 32'h7FFF_FFFF); end
        else            begin err = 0; value = 32'(neg ? -v : v); end
    endtask

    task automatic drive(input bit s, input byte c, input bit v, input bit e);
        bus_s.num_start = s; bus_s.num_char = c; bus_s.num_valid = v; bus_s.num_end = e;
        bus_z.num_start = s; bus_z.num_char = c; bus_z.num_valid = v; bus_z.num_end = e;
    endtask

    task automatic push_exp(input bq_t tok, input longint t_end);
        exp_t es, ez;
        model(tok, 1'b1, es.value, es.err);
        model(tok, 1'b0, ez.value, ez.err);
        es.t = t_end + 14;
        ez.t = t_end + 14;
        exp_s_q.push_back(es);
        exp_z_q.push_back(ez);
        exp_conv++;
        if (es.err != 0) exp_err++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic send_token(input bq_t tok, input bit merge_end, input int gap);
        int n = tok.size();
        bit merged = merge_end && (n > 1);
        longint t_end = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(i == 0, tok[i], 1'b1, merged && (i == n - 1));
            if (merged && (i == n - 1)) t_end = $time;
        end
        if (!merged) begin
            @(posedge clk); #1;
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            t_end = $time;
        end
        push_exp(tok, t_end);
        idle(gap < 1 ? 1 : gap);
    endtask

    task automatic drain_and_count(input string tag);
        int k = 0;
        while ((exp_s_q.size() != 0 || exp_z_q.size() != 0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (exp_s_q.size() != 0 || exp_z_q.size() != 0) begin
            check({tag, "_result_timeout"}, longint'(exp_s_q.size() + exp_z_q.size()), 0);
            exp_s_q.delete();
            exp_z_q.delete();
        end
        check({tag, "_conv_sat"}, longint'(conv_s), longint'(exp_conv));
        check({tag, "_err_sat"}, longint'(err_s), longint'(exp_err));
        check({tag, "_conv_nosat"}, longint'(conv_z), longint'(exp_conv));
        check({tag, "_err_nosat"}, longint'(err_z), longint'(exp_err));
    endtask

    // Monitor: compare every presented result against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_s.result_valid) begin
                pulses_s++;
                if (exp_s_q.size() == 0) begin
                    check("unexpected_result_sat", 1, 0);
                end else begin
                    e = exp_s_q.pop_front();
                    check("value_sat", longint'(bus_s.result_value), longint'(e.value));
                    check("err_sat", longint'(bus_s.result_err), longint'(e.err));
                    check("latency_sat", longint'($time), e.t);
                end
            end
            if (bus_z.result_valid) begin
                pulses_z++;
                if (exp_z_q.size() == 0) begin
                    check("unexpected_result_nosat", 1, 0);
                end else begin
                    e = exp_z_q.pop_front();
                    check("value_nosat", longint'(bus_z.result_value), longint'(e.value));
                    check("err_nosat", longint'(bus_z.result_err), longint'(e.err));
                    check("latency_nosat", longint'($time), e.t);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        string dir[$];
        int ps, pz;
        longint t_end;

        rst_n = 1'b0;
        clear = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #22 rst_n = 1'b1;
        @(negedge clk);
        check("reset_valid", longint'(bus_s.result_valid), 0);
        check("reset_value", longint'(bus_s.result_value), 0);
        check("reset_err", longint'(bus_s.result_err), 0);
        check("reset_conv", longint'(conv_s), 0);
        check("reset_errcnt", longint'(err_z), 0);

        // Stray num_valid / num_end in IDLE must be ignored
        @(posedge clk); #1; drive(1'b0, "9", 1'b1, 1'b0);
        @(posedge clk); #1; drive(1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);

        dir = '{"123", "-2147483648", "2147483648", "99999999999", "1-2", "12a", "-",
                "2147483647", "-2147483649", "-0", "0", "0000000000042", "-99999999999999",
                "4294967295"};
        foreach (dir[i]) begin
            send_token(s2q(dir[i]), 1'b0, 2);
            drain_and_count($sformatf("dir%0d", i));
        end

        // Character and end in the same cycle
        send_token(s2q("45"), 1'b1, 2);
        drain_and_count("merged_end");

        // Restart mid-token: only "8" produces a result
        @(posedge clk); #1; drive(1'b1, "7", 1'b1, 1'b0);
        @(posedge clk); #1; drive(1'b1, "8", 1'b1, 1'b0);
        @(posedge clk); #1; drive(1'b0, 8'h00, 1'b0, 1'b1);
        t_end = $time;
        push_exp(s2q("8"), t_end);
        idle(2);
        drain_and_count("restart");

        // Randomized tokens
        for (int n = 0; n < 150; n++) begin
            bq_t tok;
            int len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                int r = $urandom_range(0, 99);
                if (i == 0 && r < 25)  tok.push_back("-");
                else if (r < 88)       tok.push_back(byte'("0" + $urandom_range(0, 9)));
                else if (r < 92)       tok.push_back("-");
                else if (r < 96)       tok.push_back(byte'("a" + $urandom_range(0, 25)));
                else                   tok.push_back(" ");
            end
            send_token(tok, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            drain_and_count("rand");
        end

        // Clear mid-token: no result, counters back to zero
        ps = pulses_s; pz = pulses_z;
        @(posedge clk); #1; drive(1'b1, "1", 1'b1, 1'b0);
        @(posedge clk); #1; drive(1'b0, "2", 1'b1, 1'b0);
        @(posedge clk); #1; drive(1'b0, "3", 1'b1, 1'b0); clear = 1'b1;
        @(posedge clk); #1; drive(1'b0, 8'h00, 1'b0, 1'b1); clear = 1'b0;
        idle(4);
        exp_conv = 0; exp_err = 0;
        check("clear_no_result_sat", longint'(pulses_s), longint'(ps));
        check("clear_no_result_nosat", longint'(pulses_z), longint'(pz));
        drain_and_count("clear");

        send_token(s2q("x7"), 1'b0, 2);
        drain_and_count("post_clear");

        // Async reset mid-token
        ps = pulses_s; pz = pulses_z;
        @(posedge clk); #1; drive(1'b1, "4", 1'b1, 1'b0);
        @(posedge clk); #1; drive(1'b0, "5", 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1; drive(1'b0, 8'h00, 1'b0, 1'b1);
        idle(4);
        exp_conv = 0; exp_err = 0;
        check("rst_no_result_sat", longint'(pulses_s), longint'(ps));
        check("rst_no_result_nosat", longint'(pulses_z), longint'(pz));
        check("rst_value", longint'(bus_s.result_value), 0);
        drain_and_count("reset");

        // Back-to-back tokens with 2-cycle gaps
        send_token(s2q("5"), 1'b0, 2);
        send_token(s2q("-6"), 1'b0, 2);
        drain_and_count("b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
